// File: rtl/data_mem_responder.sv
// Word-addressed 64-bit data memory behind a valid/ready request port.
// One request at a time; the response strobe arrives LATENCY edges after acceptance.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we;
    logic        addr_err;
    logic [IW-1:0] word_idx;

    logic [63:0] mem_q [DEPTH];

    // Range test is done on the full unsigned word index so large addresses never alias.
    assign addr_err = (addr_q[2:0] != 3'b000) || ({3'b000, addr_q[63:3]} >= 64'(DEPTH));
    assign word_idx = addr_q[IW+2:3];

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = addr_err;
                    if (!addr_err) begin
                        if (write_q) mem_we = 1'b1;
                        else         rdata_d = mem_q[word_idx];
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset, and reset only blocks a pending store.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[word_idx] <= wdata_q;
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [63:0] resp_rdata;
    logic        r1_valid, r1_write;
    logic [63:0] r1_addr, r1_wdata;
    logic        r1_ready, r1_resp_valid, r1_resp_err, r1_busy;
    logic [63:0] r1_resp_rdata;

    int tests = 0;
    int fails = 0;
    int acc;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(128), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH(128), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(r1_valid), .req_write(r1_write), .req_addr(r1_addr), .req_wdata(r1_wdata),
        .req_ready(r1_ready), .resp_valid(r1_resp_valid), .resp_rdata(r1_resp_rdata),
        .resp_err(r1_resp_err), .busy(r1_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic w, input logic [63:0] a,
                         input logic [63:0] wd);
        if (sel) begin
            r1_valid = v; r1_write = w; r1_addr = a; r1_wdata = wd;
        end else begin
            req_valid = v; req_write = w; req_addr = a; req_wdata = wd;
        end
    endtask

    // Starts and ends on a falling edge with the selected instance idle.
    task automatic transact(input bit sel, input int lat, input string tag, input logic w,
                            input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] exp_rd, input logic exp_err);
        check({tag, ":ready_idle"}, sel ? r1_ready : req_ready, 64'd1);
        drive(sel, 1'b1, w, a, wd);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 64'd0, 64'd0);
        check({tag, ":busy_wait"},  sel ? r1_busy : busy, 64'd1);
        check({tag, ":ready_wait"}, sel ? r1_ready : req_ready, 64'd0);
        check({tag, ":valid_wait"}, sel ? r1_resp_valid : resp_valid, 64'd0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({tag, ":valid_early"}, sel ? r1_resp_valid : resp_valid, 64'd0);
        end
        @(negedge clk);
        check({tag, ":valid_resp"}, sel ? r1_resp_valid : resp_valid, 64'd1);
        check({tag, ":rdata"},      sel ? r1_resp_rdata : resp_rdata, exp_rd);
        check({tag, ":err"},        sel ? r1_resp_err : resp_err, 64'(exp_err));
        check({tag, ":ready_resp"}, sel ? r1_ready : req_ready, 64'd0);
        @(negedge clk);
        check({tag, ":valid_after"}, sel ? r1_resp_valid : resp_valid, 64'd0);
        check({tag, ":busy_after"},  sel ? r1_busy : busy, 64'd0);
        check({tag, ":rdata_after"}, sel ? r1_resp_rdata : resp_rdata, 64'd0);
        check({tag, ":err_after"},   sel ? r1_resp_err : resp_err, 64'd0);
    endtask

    initial begin
        // Reset held with a request pending: reset must win.
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
        repeat (2) @(negedge clk);
        check("rst:resp_valid", resp_valid, 64'd0);
        check("rst:resp_rdata", resp_rdata, 64'd0);
        check("rst:resp_err",   resp_err,   64'd0);
        check("rst:busy",       busy,       64'd0);
        check("rst:req_ready",  req_ready,  64'd1);
        check("rst:busy_l1",    r1_busy,    64'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        check("rst:no_accept", busy, 64'd0);

        // Store/load round trip and boundary addresses.
        transact(1'b0, 2, "st10",   1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0);
        transact(1'b0, 2, "ld10",   1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        transact(1'b0, 2, "st18",   1'b1, 64'h18, 64'h11112222_33334444, 64'd0, 1'b0);
        transact(1'b0, 2, "st3f8",  1'b1, 64'h3F8, 64'h01234567_89ABCDEF, 64'd0, 1'b0);
        transact(1'b0, 2, "ld3f8",  1'b0, 64'h3F8, 64'd0, 64'h01234567_89ABCDEF, 1'b0);
        transact(1'b0, 2, "ld0c",   1'b0, 64'h0C, 64'd0, 64'd0, 1'b1);
        transact(1'b0, 2, "st400",  1'b1, 64'h400, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1);
        transact(1'b0, 2, "ld0",    1'b0, 64'h0, 64'd0, 64'd0, 1'b0);
        transact(1'b0, 2, "stwrap", 1'b1, 64'h10000000_00000010, 64'h0BAD0BAD_0BAD0BAD, 64'd0, 1'b1);
        transact(1'b0, 2, "ld10b",  1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        transact(1'b0, 2, "ldtop",  1'b0, 64'hFFFFFFFF_FFFFFFF8, 64'd0, 64'd0, 1'b1);

        // req_valid held high with alternating addresses: one acceptance every four edges.
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            check("hold:ready", req_ready,  64'((k % 4) == 0));
            check("hold:busy",  busy,       64'((k % 4) != 0));
            check("hold:valid", resp_valid, 64'((k % 4) == 3));
            if ((k % 4) == 3)
                check("hold:rdata", resp_rdata,
                      ((k - 3) & 4) != 0 ? 64'hDEADBEEF_CAFEF00D : 64'h11112222_33334444);
            drive(1'b0, k < 14, 1'b0, (k & 4) != 0 ? 64'h10 : 64'h18, 64'd0);
            if (req_valid && req_ready) acc++;
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("hold:accepts", 64'(acc), 64'd4);
        check("hold:idle", req_ready, 64'd1);

        // Reset one cycle after accepting a store aborts it.
        drive(1'b0, 1'b1, 1'b1, 64'h8, 64'h55);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("abort:busy_pre", busy, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort:ready", req_ready,  64'd1);
        check("abort:busy",  busy,       64'd0);
        check("abort:valid", resp_valid, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort:no_resp", resp_valid, 64'd0);
        end
        transact(1'b0, 2, "ld8", 1'b0, 64'h8, 64'd0, 64'd0, 1'b0);

        // LATENCY=1 instance: response in the cycle after E0+1, then back-to-back traffic.
        transact(1'b1, 1, "l1ld0",  1'b0, 64'h0, 64'd0, 64'd0, 1'b0);
        transact(1'b1, 1, "l1st20", 1'b1, 64'h20, 64'hA5A5A5A5_5A5A5A5A, 64'd0, 1'b0);
        transact(1'b1, 1, "l1ld20", 1'b0, 64'h20, 64'd0, 64'hA5A5A5A5_5A5A5A5A, 1'b0);
        transact(1'b1, 1, "l1err",  1'b0, 64'h401, 64'd0, 64'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
